servo_pwm_gen: RTL and testbench

Generates the 50 Hz servo drive pulse from a commanded angle (0–180°) and feeds the PWM input of the servo output gate, which forwards it to the SG90 signal pin. A new angle is accepted through a valid/ready handshake and applied only on a period boundary, so pulses are never truncated. An optional slew limiter steps the active angle toward the target over several periods.

---
 rtl/servo_pkg.sv | 17 +
 rtl/servo_pwm_gen_if.sv | 25 ++
 rtl/servo_ramp.sv | 33 +++
 rtl/servo_pwm_gen.sv | 146 ++++++++++++++
 tb/tb_servo_pwm_gen.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// Shared types and constants for the servo PWM generator.
//   angle_t    : commanded / active angle in degrees (8 bit)
//   MAX_ANGLE  : largest legal angle; larger commands saturate here
//   state_t    : pulse FSM states (IDLE, HIGH, LOW)
package servo_pkg;

   typedef logic [7:0] angle_t;

   localparam angle_t MAX_ANGLE = 8'd180;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

endpackage

// File: rtl/servo_pwm_gen_if.sv
// Angle command channel for servo_pwm_gen (valid/ready handshake).
//   cmd_angle : target angle in degrees, clamped to MAX_ANGLE by the slave
//   cmd_valid : command strobe, driven by the master
//   cmd_ready : high while the slave holds no pending command
// master modport: command source; slave modport: servo_pwm_gen.
interface servo_pwm_gen_if;
   import servo_pkg::*;

   angle_t cmd_angle;
   logic   cmd_valid;
   logic   cmd_ready;

   modport master (
      output cmd_angle,
      output cmd_valid,
      input  cmd_ready
   );

   modport slave (
      input  cmd_angle,
      input  cmd_valid,
      output cmd_ready
   );

endinterface

// File: rtl/servo_ramp.sv
// Slew limiter for the servo angle: returns the angle one period boundary
// closer to target, moving at most RAMP_STEP degrees.
// Only instantiated when SERVO_RAMP_EN is defined.
//   cur    : angle used in the period that is ending
//   target : commanded angle
//   nxt    : angle for the next period
module servo_ramp
   import servo_pkg::*;
#(
   parameter int RAMP_STEP = 2
) (
   input  angle_t cur,
   input  angle_t target,
   output angle_t nxt
);

   localparam logic signed [9:0] STEP_S = 10'(RAMP_STEP);

   // Saturate the signed distance to +/-RAMP_STEP and apply it to cur.
   function automatic angle_t slew_limit(angle_t c, angle_t t);
      logic signed [9:0] diff;
      diff = $signed({2'b00, t}) - $signed({2'b00, c});
      if (diff > STEP_S)
         return c + angle_t'(RAMP_STEP);
      else if (diff < -STEP_S)
         return c - angle_t'(RAMP_STEP);
      else
         return t;
   endfunction

   assign nxt = slew_limit(cur, target);

endmodule

// File: rtl/servo_pwm_gen.sv
// 50 Hz servo pulse generator. The high time per period is
// MIN_CYC + cur_angle*STEP_CYC clock cycles; new angles are taken through a
// valid/ready handshake and only applied at the start of a period so that a
// pulse is never cut short.
// Optional feature: define SERVO_RAMP_EN to slew cur_angle toward the target
// by at most RAMP_STEP degrees per period (default build copies directly).
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   en           : run request, honoured only at period boundaries
//   cmd          : angle command channel (servo_pwm_gen_if slave)
//   pwm          : registered servo pulse
//   period_start : one-cycle strobe on the first high cycle of each period
//   cur_angle    : angle in effect for the current period
module servo_pwm_gen
   import servo_pkg::*;
#(
   parameter int PERIOD_CYC = 2_000_000,
   parameter int MIN_CYC    = 100_000,
   parameter int STEP_CYC   = 555,
   parameter int INIT_ANGLE = 90,
   parameter int RAMP_STEP  = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   servo_pwm_gen_if.slave  cmd,
   output logic            pwm,
   output logic            period_start,
   output angle_t          cur_angle
);

   localparam int CW = $clog2(PERIOD_CYC) + 1;
   typedef logic [CW-1:0] cyc_t;

   localparam cyc_t   LAST_CYC = cyc_t'(PERIOD_CYC - 1);
   localparam angle_t INIT_A   = angle_t'(INIT_ANGLE);

   // The widest pulse must leave at least one low cycle in the period.
   if (MIN_CYC + int'(MAX_ANGLE) * STEP_CYC >= PERIOD_CYC || RAMP_STEP < 1) begin : g_param_check
      $error("servo_pwm_gen: illegal timing parameters");
   end

   function automatic angle_t clamp_angle(angle_t a);
      return (a > MAX_ANGLE) ? MAX_ANGLE : a;
   endfunction

   // All operands widened before the multiply so the product cannot truncate.
   function automatic cyc_t calc_width(angle_t a);
      return cyc_t'(MIN_CYC) + cyc_t'(a) * cyc_t'(STEP_CYC);
   endfunction

   state_t state, state_nxt;
   cyc_t   cnt, cnt_nxt;
   cyc_t   width_r;
   angle_t target;
   angle_t angle_nxt;
   logic   pending;
   logic   accept;
   logic   boundary;

   assign accept        = cmd.cmd_valid && !pending;
   assign cmd.cmd_ready = !pending;

`ifdef SERVO_RAMP_EN
   servo_ramp #(
      .RAMP_STEP (RAMP_STEP)
   ) u_ramp (
      .cur    (cur_angle),
      .target (target),
      .nxt    (angle_nxt)
   );
`else
   assign angle_nxt = target;
`endif

   // boundary marks the cycle whose clock edge starts a new period.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      boundary  = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (en) begin
               state_nxt = HIGH;
               boundary  = 1'b1;
            end
         end
         HIGH: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == width_r - 1'b1)
               state_nxt = LOW;
         end
         LOW: begin
            if (cnt == LAST_CYC) begin
               cnt_nxt = '0;
               if (en) begin
                  state_nxt = HIGH;
                  boundary  = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // ---- registered state and outputs ----
   // pwm and period_start are registered from the next state, so they line
   // up with the first cycle the FSM spends in HIGH.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         pwm          <= 1'b0;
         period_start <= 1'b0;
         cur_angle    <= INIT_A;
         target       <= INIT_A;
         width_r      <= calc_width(INIT_A);
         pending      <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         pwm          <= (state_nxt == HIGH);
         period_start <= boundary;
         if (boundary) begin
            cur_angle <= angle_nxt;
            width_r   <= calc_width(angle_nxt);
         end
         // A command taken in the boundary cycle stays pending for the next one.
         if (accept) begin
            target  <= clamp_angle(cmd.cmd_angle);
            pending <= 1'b1;
         end else if (boundary) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed testbench for servo_pwm_gen with a short 400-cycle period.
// Works with or without SERVO_RAMP_EN defined.
module tb_servo_pwm_gen;
   import servo_pkg::*;

   localparam int PERIOD_CYC = 400;
   localparam int MIN_CYC    = 20;
   localparam int STEP_CYC   = 1;
   localparam int INIT_ANGLE = 90;
   localparam int RAMP_STEP  = 2;

   logic   clk = 1'b0;
   logic   reset = 1'b1;
   logic   en = 1'b0;
   logic   pwm;
   logic   period_start;
   angle_t cur_angle;

   int checks = 0;
   int errors = 0;

   servo_pwm_gen_if cmd_if ();

   servo_pwm_gen #(
      .PERIOD_CYC (PERIOD_CYC),
      .MIN_CYC    (MIN_CYC),
      .STEP_CYC   (STEP_CYC),
      .INIT_ANGLE (INIT_ANGLE),
      .RAMP_STEP  (RAMP_STEP)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .cmd          (cmd_if),
      .pwm          (pwm),
      .period_start (period_start),
      .cur_angle    (cur_angle)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] ang;
      bit         dup;
      int         exp_cur;
      int         exp_hi;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int clamp_m(int a);
      return (a > 180) ? 180 : a;
   endfunction

   function automatic int step_m(int cur, int tgt);
`ifdef SERVO_RAMP_EN
      if (tgt > cur + RAMP_STEP) return cur + RAMP_STEP;
      if (tgt < cur - RAMP_STEP) return cur - RAMP_STEP;
`endif
      return tgt;
   endfunction

   // Runs one full period starting on its first cycle (sampled on negedge),
   // optionally issuing a command at cycle cmd_at (plus an ignored duplicate
   // 5 cycles later) and dropping en at cycle drop_at.
   task automatic run_period(input int cmd_at, input logic [7:0] ang, input bit dup,
                             input int drop_at, output int hi, output int rl, output int xps);
      hi = 0;
      rl = 0;
      xps = 0;
      for (int k = 0; k < PERIOD_CYC; k++) begin
         if (pwm) hi++;
         if (!cmd_if.cmd_ready) rl++;
         if (k > 0 && period_start) xps++;
         if (k == cmd_at) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_angle = ang;
         end else if (k == cmd_at + 1) begin
            cmd_if.cmd_valid = 1'b0;
         end
         if (dup && k == cmd_at + 5) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_angle = 8'd10;
         end else if (dup && k == cmd_at + 6) begin
            cmd_if.cmd_valid = 1'b0;
         end
         if (k == drop_at) en = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      int hi, rl, xps, cur_m, tgt_m, e_cur, e_hi, idle_hi, idle_ps;
      int ramp_exp[4];

      vecs[0] = '{8'd0,   1'b0, 0,   20};
      vecs[1] = '{8'd200, 1'b1, 180, 200};
      vecs[2] = '{8'd45,  1'b0, 45,  65};
      vecs[3] = '{8'd180, 1'b1, 180, 200};
      vecs[4] = '{8'd90,  1'b0, 90,  110};
`ifdef SERVO_RAMP_EN
      ramp_exp = '{112, 114, 116, 116};
`else
      ramp_exp = '{116, 116, 116, 116};
`endif

      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_angle = 8'd0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_pwm", int'(pwm), 0);
      chk("reset_period_start", int'(period_start), 0);
      chk("reset_cmd_ready", int'(cmd_if.cmd_ready), 1);
      chk("reset_cur_angle", int'(cur_angle), 90);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_pwm", int'(pwm), 0);

      // Start: first high cycle comes one cycle after en is sampled
      en = 1'b1;
      @(negedge clk);
      chk("start_period_start", int'(period_start), 1);
      chk("start_pwm", int'(pwm), 1);
      cur_m = 90;
      tgt_m = 90;
      run_period(-1, 8'd0, 1'b0, -1, hi, rl, xps);
      chk("init_high", hi, 110);
      chk("init_extra_ps", xps, 0);
      chk("init_next_ps", int'(period_start), 1);
      cur_m = step_m(cur_m, tgt_m);

      // 90 -> 96: direct copy, or ramped in 2-degree steps
      run_period(50, 8'd96, 1'b0, -1, hi, rl, xps);
      chk("ramp_cmd_high", hi, 110);
      chk("ramp_ready_low", rl, 349);
      chk("ramp_ready_back", int'(cmd_if.cmd_ready), 1);
      tgt_m = 96;
      cur_m = step_m(cur_m, tgt_m);
      for (int i = 0; i < 4; i++) begin
         run_period(-1, 8'd0, 1'b0, -1, hi, rl, xps);
         chk("ramp_high", hi, ramp_exp[i]);
         cur_m = step_m(cur_m, tgt_m);
      end

      // Table: command mid-period, applied only from the next period
      for (int v = 0; v < 5; v++) begin
         run_period(50, vecs[v].ang, vecs[v].dup, -1, hi, rl, xps);
         chk("tbl_cur_period_high", hi, MIN_CYC + cur_m * STEP_CYC);
         chk("tbl_ready_low", rl, 349);
         chk("tbl_ready_back", int'(cmd_if.cmd_ready), 1);
         chk("tbl_period_start", int'(period_start), 1);
         tgt_m = clamp_m(int'(vecs[v].ang));
         cur_m = step_m(cur_m, tgt_m);
`ifdef SERVO_RAMP_EN
         e_cur = cur_m;
         e_hi  = MIN_CYC + cur_m * STEP_CYC;
`else
         e_cur = vecs[v].exp_cur;
         e_hi  = vecs[v].exp_hi;
`endif
         chk("tbl_cur_angle", int'(cur_angle), e_cur);
         run_period(-1, 8'd0, 1'b0, -1, hi, rl, xps);
         chk("tbl_next_high", hi, e_hi);
         cur_m = step_m(cur_m, tgt_m);
      end

      // en dropped at counter 50 in HIGH: period completes, then IDLE
      run_period(-1, 8'd0, 1'b0, 50, hi, rl, xps);
      chk("drop_high", hi, MIN_CYC + cur_m * STEP_CYC);
      chk("drop_extra_ps", xps, 0);
      chk("drop_no_ps", int'(period_start), 0);
      chk("drop_pwm", int'(pwm), 0);
      idle_hi = 0;
      idle_ps = 0;
      for (int k = 0; k < 30; k++) begin
         if (pwm) idle_hi++;
         if (period_start) idle_ps++;
         @(negedge clk);
      end
      chk("idle_pwm_high_cycles", idle_hi, 0);
      chk("idle_ps_count", idle_ps, 0);
      en = 1'b1;
      @(negedge clk);
      chk("restart_ps", int'(period_start), 1);
      chk("restart_pwm", int'(pwm), 1);

      // Reset at counter 60 in HIGH with a command pending
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_angle = 8'd30;
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      repeat (59) @(negedge clk);
      chk("pre_reset_pwm", int'(pwm), 1);
      chk("pre_reset_ready", int'(cmd_if.cmd_ready), 0);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_pwm", int'(pwm), 0);
      chk("rst_period_start", int'(period_start), 0);
      chk("rst_cmd_ready", int'(cmd_if.cmd_ready), 1);
      chk("rst_cur_angle", int'(cur_angle), 90);
      @(negedge clk);
      chk("rst_hold_pwm", int'(pwm), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_ps", int'(period_start), 1);
      run_period(-1, 8'd0, 1'b0, -1, hi, rl, xps);
      chk("post_rst_high", hi, 110);
      chk("post_rst_next_ps", int'(period_start), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
